// File: rtl/dmem_hs_port.sv
// Single-outstanding data-memory port with valid/ready request and response channels,
// programmable wait states and fault reporting for misaligned, illegal and out-of-range accesses.
module dmem_hs_port #(
  parameter int ADDR_W  = 17,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);
  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | wait states counting down; access happens when counter hits 0
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic [31:0] ram [WORDS];

  logic              misaligned, illegal, out_of_range, fault;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       rd_word, load_val, wdata_rep;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [3:0]        byte_mask;
  logic              commit, do_store;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Fault checks and datapath operate on the latched request only.
  always_comb begin
    misaligned   = ((op_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((op_q == 3'b010) && (addr_q[1:0] != 2'b00));
    illegal      = (op_q == 3'b011) || (op_q[2:1] == 2'b11) || (we_q && op_q[2]);
    out_of_range = (addr_q[31:ADDR_W] != '0);
    fault        = misaligned || illegal || out_of_range;
    word_idx     = addr_q[ADDR_W-1:2];
    rd_word      = ram[word_idx];
    rd_byte      = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half      = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (op_q[1:0])
      2'b00: begin
        load_val  = {(op_q[2] ? 24'h0 : {24{rd_byte[7]}}), rd_byte};
        byte_mask = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        load_val  = {(op_q[2] ? 16'h0 : {16{rd_half[15]}}), rd_half};
        byte_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        load_val  = rd_word;
        byte_mask = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
    commit   = (state_q == WAIT) && (cnt_q == 3'd0);
    do_store = commit && we_q && !fault;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = (fault || we_q) ? 32'h0 : load_val;
          fault_d = fault;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_fault = fault_q;
  end

  // Contents are not reset; a store lands only on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (!reset && do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_mask[i]) ram[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_hs_port.sv
// Directed bench for dmem_hs_port: instance A at LATENCY=1, instance B at LATENCY=4.
module tb_dmem_hs_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_we, rsp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        req_valid_a, req_valid_b;
  logic        rdy_a, rv_a, f_a, rdy_b, rv_b, f_b;
  logic [31:0] rd_a, rd_b;
  int total = 0;
  int bad = 0;

  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                         OP_BU = 3'b100, OP_HU = 3'b101;

  always #5 clk = ~clk;

  dmem_hs_port #(.ADDR_W(17), .LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(rdy_a),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_fault(f_a));

  dmem_hs_port #(.ADDR_W(17), .LATENCY(4)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(rdy_b),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_fault(f_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
  endtask

  // One full access with rsp_ready high; checks accept, latency, data and fault.
  task automatic acc(input bit sel, input bit we, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_f,
                     input string tag);
    int lat;
    chk({tag, "/ready"}, {31'b0, sel ? rdy_b : rdy_a}, 32'd1);
    drive(we, op, addr, wdata);
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(sel ? rv_b : rv_a) && lat < 20);
    chk({tag, "/lat"}, lat, sel ? 32'd4 : 32'd1);
    chk({tag, "/rdata"}, sel ? rd_b : rd_a, exp_rd);
    chk({tag, "/fault"}, {31'b0, sel ? f_b : f_a}, {31'b0, exp_f});
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    reset = 1'b1; rsp_ready = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0;
    drive(1'b0, OP_W, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst/ready", {31'b0, rdy_a}, 32'd1);
    chk("rst/valid", {31'b0, rv_a}, 32'd0);
    chk("rst/rdata", rd_a, 32'd0);
    chk("rst/fault", {31'b0, f_a}, 32'd0);

    acc(0, 1, OP_W,  32'h100, 32'hDEADBEEF, 32'h0, 0, "t1_sw");
    acc(0, 0, OP_W,  32'h100, 32'h0, 32'hDEADBEEF, 0, "t1_lw");

    acc(0, 1, OP_B,  32'h102, 32'h00000011, 32'h0, 0, "t2_sb");
    acc(0, 0, OP_B,  32'h103, 32'h0, 32'hFFFFFFDE, 0, "t2_lb");
    acc(0, 0, OP_BU, 32'h103, 32'h0, 32'h000000DE, 0, "t2_lbu");
    acc(0, 0, OP_W,  32'h100, 32'h0, 32'hDE11BEEF, 0, "t2_lw");

    acc(0, 1, OP_H,  32'h106, 32'h00008001, 32'h0, 0, "t3_sh");
    acc(0, 0, OP_H,  32'h106, 32'h0, 32'hFFFF8001, 0, "t3_lh");
    acc(0, 0, OP_HU, 32'h106, 32'h0, 32'h00008001, 0, "t3_lhu");

    acc(0, 0, OP_W,  32'h101, 32'h0, 32'h0, 1, "t4_lw_mis");
    acc(0, 0, OP_H,  32'h103, 32'h0, 32'h0, 1, "t4_lh_mis");
    acc(0, 1, OP_BU, 32'h100, 32'h000000FF, 32'h0, 1, "t4_sb_ill");
    acc(0, 0, OP_W,  32'h00020000, 32'h0, 32'h0, 1, "t4_lw_oor");
    acc(0, 1, OP_W,  32'h00020100, 32'h55555555, 32'h0, 1, "t4_sw_oor");
    acc(0, 0, 3'b111, 32'h100, 32'h0, 32'h0, 1, "t4_op111");
    acc(0, 0, OP_W,  32'h100, 32'h0, 32'hDE11BEEF, 0, "t4_lw_after");

    // LATENCY=4 instance: held response with a request pulse that must be ignored.
    acc(1, 1, OP_W, 32'h300, 32'hA5A50F0F, 32'h0, 0, "t5_sw");
    rsp_ready = 1'b0;
    drive(1'b0, OP_W, 32'h300, 32'h0);
    req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat < 4) chk("t5/ready_wait", {31'b0, rdy_b}, 32'd0);
    end while (!rv_b && lat < 20);
    chk("t5/lat", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        drive(1'b1, OP_W, 32'h300, 32'h0);
        req_valid_b = 1'b1;
      end
      @(posedge clk); #1;
      req_valid_b = 1'b0;
      chk("t5/hold_valid", {31'b0, rv_b}, 32'd1);
      chk("t5/hold_rdata", rd_b, 32'hA5A50F0F);
      chk("t5/hold_fault", {31'b0, f_b}, 32'd0);
      chk("t5/hold_ready", {31'b0, rdy_b}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5/drop_valid", {31'b0, rv_b}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t5/idle_ready", {31'b0, rdy_b}, 32'd1);
      @(posedge clk); #1;
    end
    acc(1, 0, OP_W, 32'h300, 32'h0, 32'hA5A50F0F, 0, "t5_lw_after");

    // Reset two cycles into WAIT drops the store.
    acc(1, 1, OP_W, 32'h200, 32'hCAFEF00D, 32'h0, 0, "t6_sw_old");
    drive(1'b1, OP_W, 32'h200, 32'h12345678);
    req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t6/no_rsp", {31'b0, rv_b}, 32'd0);
      @(posedge clk); #1;
    end
    acc(1, 0, OP_W, 32'h200, 32'h0, 32'hCAFEF00D, 0, "t6_lw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
